// File: rtl/mmu_line_responder.sv
// Line/MMIO responder between L1 and a word RAM / MMIO port.
// Optional MMIO ack timeout: define MMU_MMIO_TIMEOUT_EN.
module mmu_line_responder #(
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter logic [7:0]  TIMEOUT_CYC = 8'd255
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  input  logic         l1_mmu_req_read,
  input  logic         l1_mmu_req_write,
  input  logic [31:0]  l1_mmu_req_addr,
  input  logic [255:0] l1_mmu_write_data,
  output logic         mmu_l1_read_done,
  output logic         mmu_l1_write_done,
  output logic [255:0] mmu_l1_read_data,
  output logic [31:0]  mem_addr,
  output logic         mem_we,
  output logic         mem_re,
  output logic [31:0]  mem_wdata,
  input  logic [31:0]  mem_rdata,
  output logic         mmio_req,
  output logic         mmio_we,
  output logic [31:0]  mmio_req_addr,
  output logic [31:0]  mmio_wdata,
  input  logic [31:0]  mmio_rdata,
  input  logic         mmio_ack
);

  typedef enum logic [2:0] {
    IDLE, LINE_RD, LINE_WR, MMIO, RESP
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     beat_q, beat_d, nbeat;
  logic [31:5]    addr_q, addr_d;
  logic [255:0]   wbuf_q, wbuf_d;
  logic           wr_q, wr_d;
  logic           rvld_q, rvld_d;
  logic [2:0]     ridx_q, ridx_d;
  logic           ack_q, ack_d;
  logic           rdone_q, rdone_d;
  logic           wdone_q, wdone_d;
  logic [255:0]   rdata_q, rdata_d;
  logic [31:0]    maddr_q, maddr_d;
  logic           mre_q, mre_d;
  logic           mwe_q, mwe_d;
  logic [31:0]    mwdata_q, mwdata_d;
  logic           ioreq_q, ioreq_d;
  logic           iowe_q, iowe_d;
  logic [31:0]    ioaddr_q, ioaddr_d;
  logic [31:0]    iowdata_q, iowdata_d;
  logic           is_mmio;
`ifdef MMU_MMIO_TIMEOUT_EN
  logic [7:0]     tmo_q, tmo_d;
`endif

  assign is_mmio = (l1_mmu_req_addr >= MMIO_BASE);

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    nbeat     = beat_q + 3'd1;
    addr_d    = addr_q;
    wbuf_d    = wbuf_q;
    wr_d      = wr_q;
    rvld_d    = 1'b0;
    ridx_d    = ridx_q;
    ack_d     = ack_q;
    rdone_d   = 1'b0;
    wdone_d   = 1'b0;
    rdata_d   = rdata_q;
    maddr_d   = maddr_q;
    mre_d     = mre_q;
    mwe_d     = mwe_q;
    mwdata_d  = mwdata_q;
    ioreq_d   = ioreq_q;
    iowe_d    = iowe_q;
    ioaddr_d  = ioaddr_q;
    iowdata_d = iowdata_q;
`ifdef MMU_MMIO_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (l1_mmu_req_read || l1_mmu_req_write) begin
          wr_d   = !l1_mmu_req_read;
          addr_d = l1_mmu_req_addr[31:5];
          wbuf_d = l1_mmu_write_data;
          beat_d = 3'd0;
          if (is_mmio) begin
            state_d   = MMIO;
            ioreq_d   = 1'b1;
            iowe_d    = !l1_mmu_req_read;
            ioaddr_d  = {l1_mmu_req_addr[31:2], 2'b00};
            iowdata_d = l1_mmu_write_data[31:0];
            ack_d     = 1'b0;
`ifdef MMU_MMIO_TIMEOUT_EN
            tmo_d     = 8'd0;
`endif
          end else begin
            maddr_d = {l1_mmu_req_addr[31:5], 5'd0};
            if (l1_mmu_req_read) begin
              state_d = LINE_RD;
              mre_d   = 1'b1;
            end else begin
              state_d  = LINE_WR;
              mwe_d    = 1'b1;
              mwdata_d = l1_mmu_write_data[31:0];
            end
          end
        end
      end
      LINE_RD: begin
        // RAM answers one cycle after the strobe edge
        rvld_d = mre_q;
        ridx_d = maddr_q[4:2];
        if (mre_q) begin
          if (beat_q == 3'd7) begin
            mre_d  = 1'b0;
            beat_d = 3'd0;
          end else begin
            beat_d  = nbeat;
            maddr_d = {addr_q, nbeat, 2'b00};
          end
        end
        if (rvld_q) begin
          rdata_d[{ridx_q, 5'd0} +: 32] = mem_rdata;
          if (ridx_q == 3'd7) begin
            state_d = RESP;
            rdone_d = 1'b1;
          end
        end
      end
      LINE_WR: begin
        if (beat_q == 3'd7) begin
          mwe_d   = 1'b0;
          beat_d  = 3'd0;
          wdone_d = 1'b1;
          state_d = RESP;
        end else begin
          beat_d   = nbeat;
          maddr_d  = {addr_q, nbeat, 2'b00};
          mwdata_d = wbuf_q[{nbeat, 5'd0} +: 32];
        end
      end
      MMIO: begin
        if (ack_q) begin
          state_d = RESP;
          ack_d   = 1'b0;
          rdone_d = !wr_q;
          wdone_d = wr_q;
        end else if (mmio_ack) begin
          ioreq_d = 1'b0;
          ack_d   = 1'b1;
          if (!wr_q) rdata_d = {224'd0, mmio_rdata};
        end
`ifdef MMU_MMIO_TIMEOUT_EN
        else if (tmo_q == TIMEOUT_CYC - 8'd1) begin
          ioreq_d = 1'b0;
          ack_d   = 1'b1;
          if (!wr_q) rdata_d = {224'd0, 32'hDEAD_BEEF};
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= 3'd0;
      addr_q    <= '0;
      wbuf_q    <= '0;
      wr_q      <= 1'b0;
      rvld_q    <= 1'b0;
      ridx_q    <= 3'd0;
      ack_q     <= 1'b0;
      rdone_q   <= 1'b0;
      wdone_q   <= 1'b0;
      rdata_q   <= '0;
      maddr_q   <= '0;
      mre_q     <= 1'b0;
      mwe_q     <= 1'b0;
      mwdata_q  <= '0;
      ioreq_q   <= 1'b0;
      iowe_q    <= 1'b0;
      ioaddr_q  <= '0;
      iowdata_q <= '0;
`ifdef MMU_MMIO_TIMEOUT_EN
      tmo_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      wbuf_q    <= wbuf_d;
      wr_q      <= wr_d;
      rvld_q    <= rvld_d;
      ridx_q    <= ridx_d;
      ack_q     <= ack_d;
      rdone_q   <= rdone_d;
      wdone_q   <= wdone_d;
      rdata_q   <= rdata_d;
      maddr_q   <= maddr_d;
      mre_q     <= mre_d;
      mwe_q     <= mwe_d;
      mwdata_q  <= mwdata_d;
      ioreq_q   <= ioreq_d;
      iowe_q    <= iowe_d;
      ioaddr_q  <= ioaddr_d;
      iowdata_q <= iowdata_d;
`ifdef MMU_MMIO_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign mmu_l1_read_done  = rdone_q;
  assign mmu_l1_write_done = wdone_q;
  assign mmu_l1_read_data  = rdata_q;
  assign mem_addr          = maddr_q;
  assign mem_we            = mwe_q;
  assign mem_re            = mre_q;
  assign mem_wdata         = mwdata_q;
  assign mmio_req          = ioreq_q;
  assign mmio_we           = iowe_q;
  assign mmio_req_addr     = ioaddr_q;
  assign mmio_wdata        = iowdata_q;

endmodule
